// File: rtl/snapjack_input_ctrl.sv
// rtl/snapjack_input_ctrl.sv - PS/2 and joystick input conditioning with coin pulse shaping
module snapjack_input_ctrl #(
  parameter int COIN_PULSE_CYC = 400000,
  parameter int COIN_GAP_CYC   = 400000,
  parameter int CNT_W          = 20,
  parameter int PEND_MAX       = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        joy_coin_en,
  output logic [1:0]  but_coin_s,
  output logic [1:0]  but_fire_s,
  output logic [1:0]  but_bomb_s,
  output logic [1:0]  but_select_s,
  output logic [1:0]  but_up_s,
  output logic [1:0]  but_down_s,
  output logic [1:0]  but_left_s,
  output logic [1:0]  but_right_s,
  output logic [1:0]  but_tilt_s,
  output logic        btn_test
);

  // Key latch positions
  localparam int K_UP1   = 0;
  localparam int K_DN1   = 1;
  localparam int K_LT1   = 2;
  localparam int K_RT1   = 3;
  localparam int K_FIRE1 = 4;
  localparam int K_BOMB1 = 5;
  localparam int K_ST1   = 6;
  localparam int K_ST2   = 7;
  localparam int K_COIN1 = 8;
  localparam int K_COIN2 = 9;
  localparam int K_UP2   = 10;
  localparam int K_DN2   = 11;
  localparam int K_LT2   = 12;
  localparam int K_RT2   = 13;
  localparam int K_FIRE2 = 14;
  localparam int K_BOMB2 = 15;
  localparam int K_TEST  = 16;
  localparam int NK      = 17;

  localparam int PW = (PEND_MAX < 2) ? 1 : $clog2(PEND_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYC - 1);
  localparam logic [PW-1:0]    PEND_SAT   = PW'(PEND_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } coin_state_e;

  // Only the low byte of each joystick word carries controls
  logic unused_joy;
  assign unused_joy = ^{joystick_0[15:8], joystick_1[15:8]};

  logic          tog_q, tog_d;
  logic [NK-1:0] keys_q, keys_d;
  logic          key_event;
  logic          key_pressed;
  logic          key_ext;
  logic [7:0]    key_code;

  logic [1:0] up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
  logic [1:0] fire_q, fire_d, bomb_q, bomb_d, select_q, select_d;
  logic       test_q, test_d;

  logic start1_lvl, start2_lvl;
  logic start1_prev_q, start1_prev_d, start2_prev_q, start2_prev_d;
  logic coin1_prev_q, coin1_prev_d, coin2_prev_q, coin2_prev_d;
  logic [1:0] coin_req_q, coin_req_d;

  coin_state_e      state_q [2];
  coin_state_e      state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [PW-1:0]    pend_q  [2];
  logic [PW-1:0]    pend_d  [2];
  logic [1:0]       slot_ready;
  logic [1:0]       slot_start;

  assign key_event   = ps2_key[10] ^ tog_q;
  assign key_pressed = ps2_key[9];
  assign key_ext     = ps2_key[8];
  assign key_code    = ps2_key[7:0];

  // Decode a new PS/2 event into the addressed key latch; arrows accept either prefix
  always_comb begin
    tog_d  = ps2_key[10];
    keys_d = keys_q;
    if (key_event) begin
      case (key_code)
        8'h75:   keys_d[K_UP1] = key_pressed;
        8'h72:   keys_d[K_DN1] = key_pressed;
        8'h6B:   keys_d[K_LT1] = key_pressed;
        8'h74:   keys_d[K_RT1] = key_pressed;
        default: begin
          if (!key_ext) begin
            case (key_code)
              8'h14:        keys_d[K_FIRE1] = key_pressed;
              8'h29:        keys_d[K_BOMB1] = key_pressed;
              8'h05, 8'h16: keys_d[K_ST1]   = key_pressed;
              8'h06, 8'h1E: keys_d[K_ST2]   = key_pressed;
              8'h2E:        keys_d[K_COIN1] = key_pressed;
              8'h36:        keys_d[K_COIN2] = key_pressed;
              8'h2D:        keys_d[K_UP2]   = key_pressed;
              8'h2B:        keys_d[K_DN2]   = key_pressed;
              8'h23:        keys_d[K_LT2]   = key_pressed;
              8'h34:        keys_d[K_RT2]   = key_pressed;
              8'h1C:        keys_d[K_FIRE2] = key_pressed;
              8'h1B:        keys_d[K_BOMB2] = key_pressed;
              8'h2C:        keys_d[K_TEST]  = key_pressed;
              default:      ;
            endcase
          end
        end
      endcase
    end
  end

  // Merge key latches with joystick bits into active-low controls and detect coin requests
  always_comb begin
    up_d     = ~{keys_q[K_UP2]   | joystick_1[3], keys_q[K_UP1]   | joystick_0[3]};
    down_d   = ~{keys_q[K_DN2]   | joystick_1[2], keys_q[K_DN1]   | joystick_0[2]};
    left_d   = ~{keys_q[K_LT2]   | joystick_1[1], keys_q[K_LT1]   | joystick_0[1]};
    right_d  = ~{keys_q[K_RT2]   | joystick_1[0], keys_q[K_RT1]   | joystick_0[0]};
    fire_d   = ~{keys_q[K_FIRE2] | joystick_1[6], keys_q[K_FIRE1] | joystick_0[6]};
    bomb_d   = ~{keys_q[K_BOMB2] | joystick_1[7], keys_q[K_BOMB1] | joystick_0[7]};
    start1_lvl = keys_q[K_ST1] | joystick_0[4] | joystick_1[4];
    start2_lvl = keys_q[K_ST2] | joystick_0[5] | joystick_1[5];
    select_d = ~{start2_lvl, start1_lvl};
    test_d   = keys_q[K_TEST];

    start1_prev_d = start1_lvl;
    start2_prev_d = start2_lvl;
    coin1_prev_d  = keys_q[K_COIN1];
    coin2_prev_d  = keys_q[K_COIN2];

    // Simultaneous edges into one slot collapse into a single request
    coin_req_d[0] = (keys_q[K_COIN1] & ~coin1_prev_q)
                  | (joy_coin_en & ((start1_lvl & ~start1_prev_q) | (start2_lvl & ~start2_prev_q)));
    coin_req_d[1] = keys_q[K_COIN2] & ~coin2_prev_q;
  end

  // Register key latches, edge history and control outputs; the toggle tracks ps2_key even in reset
  always_ff @(posedge clk_sys) begin
    tog_q <= tog_d;
    if (reset) begin
      keys_q        <= '0;
      up_q          <= 2'b11;
      down_q        <= 2'b11;
      left_q        <= 2'b11;
      right_q       <= 2'b11;
      fire_q        <= 2'b11;
      bomb_q        <= 2'b11;
      select_q      <= 2'b11;
      test_q        <= 1'b0;
      start1_prev_q <= 1'b0;
      start2_prev_q <= 1'b0;
      coin1_prev_q  <= 1'b0;
      coin2_prev_q  <= 1'b0;
      coin_req_q    <= 2'b00;
    end else begin
      keys_q        <= keys_d;
      up_q          <= up_d;
      down_q        <= down_d;
      left_q        <= left_d;
      right_q       <= right_d;
      fire_q        <= fire_d;
      bomb_q        <= bomb_d;
      select_q      <= select_d;
      test_q        <= test_d;
      start1_prev_q <= start1_prev_d;
      start2_prev_q <= start2_prev_d;
      coin1_prev_q  <= coin1_prev_d;
      coin2_prev_q  <= coin2_prev_d;
      coin_req_q    <= coin_req_d;
    end
  end

  // Coin slot state register: reset drops any pulse in flight and forgets pending coins
  always_ff @(posedge clk_sys) begin
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        state_q[s] <= S_IDLE;
        cnt_q[s]   <= '0;
        pend_q[s]  <= '0;
      end else begin
        state_q[s] <= state_d[s];
        cnt_q[s]   <= cnt_d[s];
        pend_q[s]  <= pend_d[s];
      end
    end
  end

  // Coin slot next state; the last gap cycle behaves as IDLE so back-to-back coins keep the exact gap
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      cnt_d[s]   = cnt_q[s];
      pend_d[s]  = pend_q[s];
      slot_ready[s] = (state_q[s] == S_IDLE) || ((state_q[s] == S_GAP) && (cnt_q[s] == '0));
      slot_start[s] = slot_ready[s] && (coin_req_q[s] || (pend_q[s] != '0));

      if (slot_start[s]) begin
        state_d[s] = S_PULSE;
        cnt_d[s]   = PULSE_LOAD;
        // A request arriving as a pending coin is consumed cancels the decrement
        if ((pend_q[s] != '0) && !coin_req_q[s]) begin
          pend_d[s] = pend_q[s] - PW'(1);
        end
      end else begin
        case (state_q[s])
          S_PULSE: begin
            if (cnt_q[s] == '0) begin
              state_d[s] = S_GAP;
              cnt_d[s]   = GAP_LOAD;
            end else begin
              cnt_d[s] = cnt_q[s] - CNT_W'(1);
            end
          end
          S_GAP: begin
            if (cnt_q[s] == '0) begin
              state_d[s] = S_IDLE;
            end else begin
              cnt_d[s] = cnt_q[s] - CNT_W'(1);
            end
          end
          default: ;
        endcase
        if (coin_req_q[s] && (state_q[s] != S_IDLE) && (pend_q[s] != PEND_SAT)) begin
          pend_d[s] = pend_q[s] + PW'(1);
        end
      end
    end
  end

  // Coin slot outputs: low exactly while the slot is in PULSE
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      but_coin_s[s] = (state_q[s] != S_PULSE);
    end
  end

  assign but_up_s     = up_q;
  assign but_down_s   = down_q;
  assign but_left_s   = left_q;
  assign but_right_s  = right_q;
  assign but_fire_s   = fire_q;
  assign but_bomb_s   = bomb_q;
  assign but_select_s = select_q;
  assign but_tilt_s   = 2'b11;
  assign btn_test     = test_q;

endmodule

// File: tb/tb_snapjack_input_ctrl.sv
// tb/tb_snapjack_input_ctrl.sv - randomized self-checking bench for snapjack_input_ctrl
module tb_snapjack_input_ctrl;

  localparam int PULSE = 4;
  localparam int GAP   = 3;
  localparam int PMAX  = 3;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        joy_coin_en;
  logic [1:0]  but_coin_s, but_fire_s, but_bomb_s, but_select_s;
  logic [1:0]  but_up_s, but_down_s, but_left_s, but_right_s, but_tilt_s;
  logic        btn_test;

  always #5 clk_sys = ~clk_sys;

  snapjack_input_ctrl #(
    .COIN_PULSE_CYC(PULSE),
    .COIN_GAP_CYC  (GAP),
    .CNT_W         (20),
    .PEND_MAX      (PMAX)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .joystick_0  (joystick_0),
    .joystick_1  (joystick_1),
    .joy_coin_en (joy_coin_en),
    .but_coin_s  (but_coin_s),
    .but_fire_s  (but_fire_s),
    .but_bomb_s  (but_bomb_s),
    .but_select_s(but_select_s),
    .but_up_s    (but_up_s),
    .but_down_s  (but_down_s),
    .but_left_s  (but_left_s),
    .but_right_s (but_right_s),
    .but_tilt_s  (but_tilt_s),
    .btn_test    (btn_test)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  // Reference model state: key levels by function, per-slot last pulse start and pending count
  logic [16:0] klat;
  logic        tog_m;
  logic        s1p, s2p, c1p, c2p;
  logic [1:0]  rq_pipe;
  int          last_start [2];
  int          pend       [2];

  int          fall_cnt [2];
  int          fall_t   [2];
  logic [1:0]  coin_prev;
  bit          gap_chk;

  logic [8:0]  tbl [0:28];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  // Index into klat for a key event, -1 for keys with no function
  function automatic int kidx(input logic ext, input logic [7:0] c);
    case (c)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: ;
    endcase
    if (ext) return -1;
    case (c)
      8'h14:        return 4;
      8'h29:        return 5;
      8'h05, 8'h16: return 6;
      8'h06, 8'h1E: return 7;
      8'h2E:        return 8;
      8'h36:        return 9;
      8'h2D:        return 10;
      8'h2B:        return 11;
      8'h23:        return 12;
      8'h34:        return 13;
      8'h1C:        return 14;
      8'h1B:        return 15;
      8'h2C:        return 16;
      default:      return -1;
    endcase
  endfunction

  // One clock: predict outputs after the coming edge, advance, then compare at the falling edge
  task automatic step();
    logic [1:0] e_up, e_dn, e_lt, e_rt, e_fire, e_bomb, e_sel, e_coin;
    logic       e_test, s1, s2, c1, c2, was_rst;
    logic [1:0] req_now, req_new;
    int         ki;
    was_rst = reset;
    if (reset) begin
      klat = '0; tog_m = ps2_key[10];
      s1p = 1'b0; s2p = 1'b0; c1p = 1'b0; c2p = 1'b0; rq_pipe = 2'b00;
      last_start = '{-100, -100}; pend = '{0, 0};
      e_up = 2'b11; e_dn = 2'b11; e_lt = 2'b11; e_rt = 2'b11;
      e_fire = 2'b11; e_bomb = 2'b11; e_sel = 2'b11; e_coin = 2'b11; e_test = 1'b0;
    end else begin
      e_up   = ~{klat[10] | joystick_1[3], klat[0] | joystick_0[3]};
      e_dn   = ~{klat[11] | joystick_1[2], klat[1] | joystick_0[2]};
      e_lt   = ~{klat[12] | joystick_1[1], klat[2] | joystick_0[1]};
      e_rt   = ~{klat[13] | joystick_1[0], klat[3] | joystick_0[0]};
      e_fire = ~{klat[14] | joystick_1[6], klat[4] | joystick_0[6]};
      e_bomb = ~{klat[15] | joystick_1[7], klat[5] | joystick_0[7]};
      s1 = klat[6] | joystick_0[4] | joystick_1[4];
      s2 = klat[7] | joystick_0[5] | joystick_1[5];
      c1 = klat[8];
      c2 = klat[9];
      e_sel  = ~{s2, s1};
      e_test = klat[16];
      req_new[0] = (c1 && !c1p) || (joy_coin_en && ((s1 && !s1p) || (s2 && !s2p)));
      req_new[1] = c2 && !c2p;
      s1p = s1; s2p = s2; c1p = c1; c2p = c2;
      req_now = rq_pipe;
      rq_pipe = req_new;
      for (int s = 0; s < 2; s++) begin
        if ((t + 1 >= last_start[s] + PULSE + GAP) && (pend[s] > 0 || req_now[s])) begin
          if (pend[s] > 0) pend[s] = pend[s] - 1 + (req_now[s] ? 1 : 0);
          last_start[s] = t + 1;
        end else if (req_now[s]) begin
          pend[s] = (pend[s] < PMAX) ? pend[s] + 1 : PMAX;
        end
        e_coin[s] = !((t + 1 >= last_start[s]) && (t + 1 < last_start[s] + PULSE));
      end
      if (ps2_key[10] != tog_m) begin
        ki = kidx(ps2_key[8], ps2_key[7:0]);
        if (ki >= 0) klat[ki] = ps2_key[9];
        tog_m = ps2_key[10];
      end
    end
    @(posedge clk_sys);
    t++;
    @(negedge clk_sys);
    check("up", but_up_s, e_up);
    check("down", but_down_s, e_dn);
    check("left", but_left_s, e_lt);
    check("right", but_right_s, e_rt);
    check("fire", but_fire_s, e_fire);
    check("bomb", but_bomb_s, e_bomb);
    check("select", but_select_s, e_sel);
    check("coin", but_coin_s, e_coin);
    check("test", btn_test, e_test);
    check("tilt", but_tilt_s, 2'b11);
    for (int s = 0; s < 2; s++) begin
      if (coin_prev[s] && !but_coin_s[s]) begin
        fall_cnt[s]++;
        if (gap_chk && fall_cnt[s] > 1) check("fall_spacing", t - fall_t[s], PULSE + GAP);
        fall_t[s] = t;
      end else if (!coin_prev[s] && but_coin_s[s] && !was_rst) begin
        check("pulse_width", t - fall_t[s], PULSE);
      end
    end
    coin_prev = but_coin_s;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic key(input logic ext, input logic pressed, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    step();
  endtask

  task automatic clr_falls();
    fall_cnt = '{0, 0};
  endtask

  initial begin
    tbl = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h175, 9'h172, 9'h16B, 9'h174,
            9'h014, 9'h029, 9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h02E,
            9'h036, 9'h036, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B,
            9'h02C, 9'h114, 9'h12E, 9'h099, 9'h000};
    reset = 1'b1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0; joy_coin_en = 1'b0;
    coin_prev = 2'b11; gap_chk = 1'b0; fall_t = '{0, 0};
    clr_falls();
    @(negedge clk_sys);
    idle(3);
    check("rst_coin", but_coin_s, 2'b11);
    check("rst_btn_test", btn_test, 1'b0);
    check("rst_select", but_select_s, 2'b11);
    reset = 1'b0;
    idle(2);

    // Arrow press: two edges of latency; extended release still clears it
    key(1'b0, 1'b1, 8'h75);
    check("t1_up_latency", but_up_s, 2'b11);
    step();
    check("t1_up_press", but_up_s, 2'b10);
    key(1'b1, 1'b0, 8'h75);
    step();
    check("t1_up_release", but_up_s, 2'b11);

    // Held coin key yields exactly one coin
    clr_falls();
    key(1'b0, 1'b1, 8'h2E);
    idle(100);
    key(1'b0, 1'b0, 8'h2E);
    idle(20);
    check("t2_slot0_coins", fall_cnt[0], 1);
    check("t2_slot1_coins", fall_cnt[1], 0);

    // Six rapid coin edges: one queued request is lost to saturation
    clr_falls();
    gap_chk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      key(1'b0, 1'b1, 8'h2E);
      key(1'b0, 1'b0, 8'h2E);
    end
    idle(60);
    gap_chk = 1'b0;
    check("t3_slot0_coins", fall_cnt[0], 5);
    check("t3_slot1_coins", fall_cnt[1], 0);

    // Joystick start with and without coin insertion
    clr_falls();
    joy_coin_en = 1'b1;
    joystick_1[4] = 1'b1;
    step();
    check("t4_select", but_select_s, 2'b10);
    step();
    check("t4_coin_latency", but_coin_s, 2'b10);
    idle(20);
    joystick_1[4] = 1'b0;
    idle(10);
    check("t4_coin_en_coins", fall_cnt[0], 1);
    clr_falls();
    joy_coin_en = 1'b0;
    joystick_1[4] = 1'b1;
    step();
    check("t4_select_noen", but_select_s, 2'b10);
    idle(20);
    joystick_1[4] = 1'b0;
    idle(5);
    check("t4_noen_coins", fall_cnt[0], 0);

    // Coin2 key and start-coin land on both slots in the same cycle
    clr_falls();
    joy_coin_en = 1'b1;
    key(1'b0, 1'b1, 8'h36);
    joystick_0[5] = 1'b1;
    step();
    step();
    check("t6_both_low", but_coin_s, 2'b00);
    idle(20);
    joystick_0[5] = 1'b0;
    key(1'b0, 1'b0, 8'h36);
    idle(10);
    joy_coin_en = 1'b0;
    check("t6_slot0_coins", fall_cnt[0], 1);
    check("t6_slot1_coins", fall_cnt[1], 1);
    check("t6_same_fall", fall_t[0], fall_t[1]);

    // Reset mid-pulse with coins queued; an event pending at reset release is ignored
    key(1'b0, 1'b1, 8'h2E);
    key(1'b0, 1'b0, 8'h2E);
    key(1'b0, 1'b1, 8'h2E);
    key(1'b0, 1'b0, 8'h2E);
    key(1'b0, 1'b1, 8'h2E);
    check("t5_pulse_active", but_coin_s, 2'b10);
    reset = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h2E};
    step();
    check("t5_reset_coin", but_coin_s, 2'b11);
    clr_falls();
    step();
    reset = 1'b0;
    idle(30);
    check("t5_no_coin_after_reset", fall_cnt[0], 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) begin
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), tbl[$urandom_range(0, 28)]};
      end else if (r < 40) begin
        if ($urandom_range(0, 1) == 0) joystick_0[$urandom_range(0, 7)] ^= 1'b1;
        else                           joystick_1[$urandom_range(0, 7)] ^= 1'b1;
      end else if (r == 40) begin
        joy_coin_en = ~joy_coin_en;
      end else if (r == 41 && $urandom_range(0, 3) == 0) begin
        reset = 1'b1;
      end
      step();
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
